sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM read master sitting directly upstream of the system-ID slave on the control fabric; it consumes that slave's readdata.
- After reset, or on request, it reads the ID word (address 1) and the timestamp word (address 0).
- Compares both against build-time expectations and publishes sticky pass/fail flags plus captured values for the boot sequencer and status LEDs.

Parameters:
- EXPECTED_ID, 32'h5124C6E2 (1361364706), ID value the hardware must return.
- EXPECTED_TS, 32'h00000000, expected timestamp word.
- CHECK_TS, 1'b0, 1 = timestamp mismatch also fails the check; 0 = timestamp is captured only.
- AUTO_START, 1'b1, 1 = launch one check sequence in the first cycle after reset deasserts.
- TIMEOUT_CYCLES, 255, maximum cycles from read acceptance to readdatavalid; 8-bit counter, legal range 1..255.
- RETRY_LIMIT, 3, retries allowed per word after a timeout; 2-bit counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a check when IDLE or DONE, ignored otherwise.
- av_address  out  1  slave word address: 1 = ID, 0 = timestamp.
- av_read  out  1  read request.
- av_readdata  in  32  slave read data.
- av_waitrequest  in  1  slave stall (tie 0 for a zero-wait slave).
- av_readdatavalid  in  1  read data qualifier.
- busy  out  1  high while a sequence is in progress.
- done  out  1  sticky; high once a sequence has finished.
- id_ok  out  1  sticky pass flag, valid while done = 1.
- ts_ok  out  1  timestamp match flag, valid while done = 1.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- err_code  out  2  0 = none, 1 = ID mismatch, 2 = timestamp mismatch (only when CHECK_TS = 1), 3 = timeout.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, retry and timeout counters cleared. Reset asserted mid-sequence aborts in the same cycle; any in-flight readdatavalid arriving afterwards is ignored.
- FSM states and transitions:
  - IDLE → REQ_ID on start, or on the first post-reset cycle when AUTO_START = 1.
  - REQ_ID: drive av_read = 1, av_address = 1; hold both stable while av_waitrequest = 1. When av_waitrequest = 0 (request accepted) → WAIT_ID, timeout counter cleared.
  - WAIT_ID: av_read = 0. On av_readdatavalid: capture id_value ← av_readdata → REQ_TS.
    - Timeout counter increments each cycle; on reaching TIMEOUT_CYCLES without data: if retry < RETRY_LIMIT, retry++ → REQ_ID; else err_code = 3 → DONE.
  - REQ_TS / WAIT_TS: identical, with av_address = 0, capture into ts_value. Retry counter clears on entry to REQ_TS.
  - CHECK: one cycle.
    - id_ok = (id_value == EXPECTED_ID) && (!CHECK_TS || ts_value == EXPECTED_TS).
    - ts_ok = (ts_value == EXPECTED_TS).
    - err_code priority: ID mismatch (1), then TS mismatch (2, only when CHECK_TS = 1).
    - → DONE.
  - DONE: busy = 0, done = 1, flags held. start → REQ_ID and clears done, id_ok, ts_ok and err_code in the same cycle.
- busy = 1 in every state except IDLE and DONE.
- readdatavalid arriving in any non-WAIT state is ignored; at most one read is ever outstanding.
- readdatavalid in the same cycle the timeout count is reached: the data wins and no retry is taken.
- start while busy: ignored.
- Latency with a zero-wait slave and readdatavalid one cycle after acceptance, from start: REQ_ID (cycle 1), WAIT_ID (2), REQ_TS (3), WAIT_TS (4), CHECK (5); done = 1 at cycle 6.
- Comparisons are full 32-bit equality; no masking.

Test Plan:
- Zero-wait slave returning 0x5124C6E2 for the ID and 0 for the timestamp, AUTO_START = 1 → done high 6 cycles after reset release; id_ok = 1, ts_ok = 1, err_code = 0, id_value = 0x5124C6E2.
- Slave returns ID 0x5124C6E3 → id_ok = 0, err_code = 1, id_value = 0x5124C6E3.
- Timestamp returns 0x4C000000, run twice: CHECK_TS = 0 → id_ok = 1, ts_ok = 0, err_code = 0; CHECK_TS = 1 → id_ok = 0, err_code = 2.
- av_waitrequest held high 5 cycles on the ID read → av_read and av_address stay stable for all 5 cycles; sequence completes normally, done 5 cycles later than baseline.
- readdatavalid never asserted, TIMEOUT_CYCLES = 4, RETRY_LIMIT = 3 → exactly 4 ID read requests issued, then done = 1, err_code = 3, id_ok = 0.
- Reset pulsed during WAIT_TS, with a late readdatavalid carrying 0xDEADBEEF → all outputs 0 immediately; ts_value remains 0; fresh auto-start sequence passes.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid slave
// over Avalon-MM and publishes sticky pass/fail flags with the captured values.
`timescale 1ns/1ps
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h5124C6E2,
  parameter logic [31:0] EXPECTED_TS    = 32'h00000000,
  parameter logic        CHECK_TS       = 1'b0,
  parameter logic        AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] RETRY_LIM   = 2'(RETRY_LIMIT);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [7:0]  to_q, to_d;
  logic [1:0]  retry_q, retry_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic [1:0]  err_q, err_d;
  logic        av_read_q, av_address_q, busy_q, done_q;
  logic        timeout_hit, id_match, ts_match;

  assign timeout_hit = (to_q + 8'd1) == TIMEOUT_LIM;
  assign id_match    = (id_value_q == EXPECTED_ID);
  assign ts_match    = (ts_value_q == EXPECTED_TS);

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    to_d       = to_q;
    retry_d    = retry_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d = REQ_ID;
          auto_d  = 1'b0;
          retry_d = 2'd0;
        end
      end
      REQ_ID: begin
        if (!av_waitrequest) begin
          state_d = WAIT_ID;
          to_d    = 8'd0;
        end
      end
      WAIT_ID: begin
        // Data arriving on the timeout cycle takes priority over a retry.
        if (av_readdatavalid) begin
          id_value_d = av_readdata;
          retry_d    = 2'd0;
          state_d    = REQ_TS;
        end else if (timeout_hit) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 2'd1;
            state_d = REQ_ID;
          end else begin
            err_d   = 2'd3;
            state_d = DONE;
          end
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      REQ_TS: begin
        if (!av_waitrequest) begin
          state_d = WAIT_TS;
          to_d    = 8'd0;
        end
      end
      WAIT_TS: begin
        if (av_readdatavalid) begin
          ts_value_d = av_readdata;
          state_d    = CHECK;
        end else if (timeout_hit) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 2'd1;
            state_d = REQ_TS;
          end else begin
            err_d   = 2'd3;
            state_d = DONE;
          end
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      CHECK: begin
        id_ok_d = id_match && (!CHECK_TS || ts_match);
        ts_ok_d = ts_match;
        if (!id_match)                 err_d = 2'd1;
        else if (CHECK_TS && !ts_match) err_d = 2'd2;
        else                           err_d = 2'd0;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = REQ_ID;
          retry_d = 2'd0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          err_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and status outputs are registered from the next state so they change with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      auto_q       <= AUTO_START;
      to_q         <= 8'd0;
      retry_q      <= 2'd0;
      id_value_q   <= 32'd0;
      ts_value_q   <= 32'd0;
      id_ok_q      <= 1'b0;
      ts_ok_q      <= 1'b0;
      err_q        <= 2'd0;
      av_read_q    <= 1'b0;
      av_address_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_q       <= auto_d;
      to_q         <= to_d;
      retry_q      <= retry_d;
      id_value_q   <= id_value_d;
      ts_value_q   <= ts_value_d;
      id_ok_q      <= id_ok_d;
      ts_ok_q      <= ts_ok_d;
      err_q        <= err_d;
      av_read_q    <= (state_d == REQ_ID) || (state_d == REQ_TS);
      av_address_q <= (state_d == REQ_ID);
      busy_q       <= !((state_d == IDLE) || (state_d == DONE));
      done_q       <= (state_d == DONE);
    end
  end

  assign av_read    = av_read_q;
  assign av_address = av_address_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign id_ok      = id_ok_q;
  assign ts_ok      = ts_ok_q;
  assign id_value   = id_value_q;
  assign ts_value   = ts_value_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: instance 0 has CHECK_TS=0 and a 4-cycle timeout, instance 1 has CHECK_TS=1,
// each driven by a small sysid slave model with configurable stalls and silence.
`timescale 1ns/1ps
module tb_sysid_boot_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        av_address[2], av_read[2], av_waitrequest[2], av_readdatavalid[2];
  logic        busy[2], done[2], id_ok[2], ts_ok[2];
  logic [31:0] av_readdata[2], id_value[2], ts_value[2];
  logic [1:0]  err_code[2];

  logic [31:0] id_data   = 32'h5124C6E2;
  logic [31:0] ts_data   = 32'h0;
  int          stall_cfg = 0;
  logic        rdv_en    = 1'b1;
  logic        ts_silent = 1'b0;
  logic        inj_rdv   = 1'b0;
  logic [31:0] inj_data  = 32'h0;

  int n_assert = 0;
  int n_fail   = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic        rdv_q = 1'b0;
      logic [31:0] rdata_q = 32'h0;
      int          stall_used = 0;
      int          id_accepts = 0;

      sysid_boot_checker #(
        .CHECK_TS      ((gi == 1) ? 1'b1 : 1'b0),
        .TIMEOUT_CYCLES((gi == 0) ? 4 : 255)
      ) u_dut (
        .clock           (clk),
        .reset           (reset),
        .start           (start),
        .av_address      (av_address[gi]),
        .av_read         (av_read[gi]),
        .av_readdata     (av_readdata[gi]),
        .av_waitrequest  (av_waitrequest[gi]),
        .av_readdatavalid(av_readdatavalid[gi]),
        .busy            (busy[gi]),
        .done            (done[gi]),
        .id_ok           (id_ok[gi]),
        .ts_ok           (ts_ok[gi]),
        .id_value        (id_value[gi]),
        .ts_value        (ts_value[gi]),
        .err_code        (err_code[gi])
      );

      assign av_waitrequest[gi]   = av_read[gi] && av_address[gi] && (stall_used < stall_cfg);
      assign av_readdatavalid[gi] = rdv_q | inj_rdv;
      assign av_readdata[gi]      = inj_rdv ? inj_data : rdata_q;

      always @(posedge clk) begin
        rdv_q <= 1'b0;
        if (reset) begin
          stall_used <= 0;
          id_accepts <= 0;
        end else begin
          if (av_waitrequest[gi]) stall_used <= stall_used + 1;
          if (av_read[gi] && !av_waitrequest[gi]) begin
            if (av_address[gi]) id_accepts <= id_accepts + 1;
            if (rdv_en && !(ts_silent && !av_address[gi])) begin
              rdv_q   <= 1'b1;
              rdata_q <= av_address[gi] ? id_data : ts_data;
            end
          end
        end
      end
    end
  endgenerate

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("[%0t] check %s: observed 0x%08h", $time, tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int t;

    // Baseline auto-start: reset state, then done exactly 6 cycles after release.
    tick(2);
    chk("rst_done", done[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_av_read", av_read[0], 0);
    chk("rst_id_value", id_value[0], 0);
    chk("rst_err", err_code[0], 0);
    reset = 1'b0;
    tick(5);
    chk("base_done_c5", done[0], 0);
    chk("base_busy_c5", busy[0], 1);
    tick(1);
    chk("base_done_c6", done[0], 1);
    chk("base_busy_c6", busy[0], 0);
    chk("base_id_ok", id_ok[0], 1);
    chk("base_ts_ok", ts_ok[0], 1);
    chk("base_err", err_code[0], 0);
    chk("base_id_value", id_value[0], 32'h5124C6E2);
    chk("base_b_id_ok", id_ok[1], 1);
    chk("base_b_err", err_code[1], 0);

    // ID mismatch, launched by start from DONE; flags clear on the start cycle.
    id_data = 32'h5124C6E3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("idmm_done_clr", done[0], 0);
    chk("idmm_id_ok_clr", id_ok[0], 0);
    chk("idmm_busy", busy[0], 1);
    tick(5);
    chk("idmm_done", done[0], 1);
    chk("idmm_id_ok", id_ok[0], 0);
    chk("idmm_err", err_code[0], 1);
    chk("idmm_id_value", id_value[0], 32'h5124C6E3);

    // Timestamp mismatch on both instances; a start pulse while busy is ignored.
    id_data = 32'h5124C6E2;
    ts_data = 32'h4C000000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("tsmm_done_c5", done[0], 0);
    tick(1);
    chk("tsmm_done_c6", done[0], 1);
    chk("tsmm_a_id_ok", id_ok[0], 1);
    chk("tsmm_a_ts_ok", ts_ok[0], 0);
    chk("tsmm_a_err", err_code[0], 0);
    chk("tsmm_a_ts_value", ts_value[0], 32'h4C000000);
    chk("tsmm_b_done", done[1], 1);
    chk("tsmm_b_id_ok", id_ok[1], 0);
    chk("tsmm_b_ts_ok", ts_ok[1], 0);
    chk("tsmm_b_err", err_code[1], 2);

    // Waitrequest held 5 cycles on the ID read: request stays stable, done 5 cycles late.
    ts_data = 32'h0;
    stall_cfg = 5;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("wait_read_c%0d", i), av_read[0], 1);
      chk($sformatf("wait_addr_c%0d", i), av_address[0], 1);
    end
    tick(5);
    chk("wait_done_c10", done[0], 0);
    tick(1);
    chk("wait_done_c11", done[0], 1);
    chk("wait_id_ok", id_ok[0], 1);

    // No readdatavalid at all: 4 ID requests, then timeout error after 21 cycles.
    stall_cfg = 0;
    rdv_en = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    t = 0;
    while (!done[0] && t < 200) begin
      tick(1);
      t++;
    end
    chk("to_done", done[0], 1);
    chk("to_latency", t, 21);
    chk("to_id_requests", g_dut[0].id_accepts, 4);
    chk("to_err", err_code[0], 3);
    chk("to_id_ok", id_ok[0], 0);

    // Reset during WAIT_TS with a late readdatavalid that must be ignored.
    rdv_en = 1'b1;
    ts_silent = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("abort_busy_wts", busy[0], 1);
    chk("abort_read_wts", av_read[0], 0);
    chk("abort_id_cap", id_value[0], 32'h5124C6E2);
    reset = 1'b1;
    tick(1);
    chk("abort_busy", busy[0], 0);
    chk("abort_id_value", id_value[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_err", err_code[0], 0);
    reset = 1'b0;
    ts_silent = 1'b0;
    inj_rdv = 1'b1;
    inj_data = 32'hDEADBEEF;
    tick(1);
    inj_rdv = 1'b0;
    chk("abort_ts_value_late", ts_value[0], 0);
    chk("abort_restart_busy", busy[0], 1);
    tick(5);
    chk("abort_rerun_done", done[0], 1);
    chk("abort_rerun_id_ok", id_ok[0], 1);
    chk("abort_rerun_ts_value", ts_value[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
